// File: rtl/ss_bus_master.sv
// Save-state bus initiator. A save walks every slave index, queries its size
// and streams header + data words to memory, closing with a terminator word.
// A restore parses that image back and writes each word to its slave.
module ss_bus_master #(
  parameter int NUM_SLAVES = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_save,
  input  logic        cmd_restore,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  ss_select,
  output logic [31:0] ss_addr,
  output logic        ss_query,
  output logic        ss_read,
  output logic        ss_write,
  output logic [63:0] ss_wdata,
  input  logic        ss_ack,
  input  logic [63:0] ss_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_QUERY, S_NEXT, S_HDR_WR, S_SL_RD, S_MEM_WR, S_TERM_WR,
    S_DONE, S_HDR_RD, S_MEM_RD, S_SL_WR
  } state_t;

  localparam logic [8:0]  NS     = 9'(NUM_SLAVES);
  localparam logic [15:0] TMO_M1 = 16'(TIMEOUT - 1);
  localparam logic [63:0] TERM   = 64'hFFFF_FFFF_FFFF_FFFF;

  state_t      state, state_nx;
  logic [8:0]  idx, idx_nx;       // one spare bit so idx+1 never wraps at 256
  logic [31:0] cnt, cnt_nx;
  logic [31:0] addr, addr_nx;
  logic [31:0] maddr, maddr_nx;
  logic [63:0] dat, dat_nx;
  logic        gap, gap_nx;       // forces strobes low for one cycle after any ack
  logic [15:0] tcnt, tcnt_nx;
  logic        err, err_nx;
  logic        ss_ok, mem_ok, tmo, ss_req;

  logic unused_rdata;
  assign unused_rdata = ^ss_rdata[63:32];

  assign ss_select = idx[7:0];
  assign ss_addr   = addr;
  assign ss_wdata  = dat;
  assign mem_addr  = maddr;
  assign error     = err;

  // Next-state, datapath updates and strobe decode
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    cnt_nx    = cnt;
    addr_nx   = addr;
    maddr_nx  = maddr;
    dat_nx    = dat;
    err_nx    = err;
    tcnt_nx   = 16'd0;
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    ss_query  = (state == S_QUERY)  && !gap;
    ss_read   = (state == S_SL_RD)  && !gap;
    ss_write  = (state == S_SL_WR)  && !gap;
    mem_rd    = ((state == S_HDR_RD) || (state == S_MEM_RD)) && !gap;
    mem_wr    = ((state == S_HDR_WR) || (state == S_MEM_WR) || (state == S_TERM_WR)) && !gap;
    mem_wdata = 64'd0;
    case (state)
      S_HDR_WR:  mem_wdata = {24'd0, idx[7:0], cnt};
      S_MEM_WR:  mem_wdata = dat;
      S_TERM_WR: mem_wdata = TERM;
      default:   mem_wdata = 64'd0;
    endcase

    // acks only count while the matching request is outstanding
    ss_req = ss_query || ss_read || ss_write;
    ss_ok  = ss_ack && ss_req;
    mem_ok = mem_ack && (mem_rd || mem_wr);
    gap_nx = ss_ok || mem_ok;
    tmo    = 1'b0;
    if (ss_req && !ss_ack) begin
      tcnt_nx = tcnt + 16'd1;
      tmo     = (tcnt == TMO_M1);
    end

    case (state)
      S_IDLE: begin
        if (cmd_save) begin
          state_nx = S_QUERY;
          idx_nx   = 9'd0;
          maddr_nx = 32'd0;
          err_nx   = 1'b0;
        end else if (cmd_restore) begin
          state_nx = S_HDR_RD;
          maddr_nx = 32'd0;
          err_nx   = 1'b0;
        end
      end
      S_QUERY: begin
        if (ss_ok) begin
          cnt_nx   = ss_rdata[31:0];
          state_nx = (ss_rdata[31:0] == 32'd0) ? S_NEXT : S_HDR_WR;
        end else if (tmo) begin
          state_nx = S_NEXT;
        end
      end
      S_HDR_WR: begin
        if (mem_ok) begin
          maddr_nx = maddr + 32'd1;
          addr_nx  = 32'd0;
          state_nx = S_SL_RD;
        end
      end
      S_SL_RD: begin
        if (ss_ok) begin
          dat_nx   = ss_rdata;
          state_nx = S_MEM_WR;
        end else if (tmo) begin
          err_nx   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_MEM_WR: begin
        if (mem_ok) begin
          maddr_nx = maddr + 32'd1;
          if (addr + 32'd1 < cnt) begin
            addr_nx  = addr + 32'd1;
            state_nx = S_SL_RD;
          end else begin
            state_nx = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (idx + 9'd1 < NS) begin
          idx_nx   = idx + 9'd1;
          state_nx = S_QUERY;
        end else begin
          state_nx = S_TERM_WR;
        end
      end
      S_TERM_WR: begin
        if (mem_ok) begin
          maddr_nx = maddr + 32'd1;
          state_nx = S_DONE;
        end
      end
      S_DONE: state_nx = S_IDLE;
      S_HDR_RD: begin
        if (mem_ok) begin
          maddr_nx = maddr + 32'd1;
          idx_nx   = {1'b0, mem_rdata[39:32]};
          cnt_nx   = mem_rdata[31:0];
          addr_nx  = 32'd0;
          if (mem_rdata == TERM)
            state_nx = S_DONE;
          else if ({1'b0, mem_rdata[39:32]} >= NS) begin
            err_nx   = 1'b1;
            state_nx = S_IDLE;
          end else if (mem_rdata[31:0] == 32'd0)
            state_nx = S_HDR_RD;
          else
            state_nx = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        if (mem_ok) begin
          maddr_nx = maddr + 32'd1;
          dat_nx   = mem_rdata;
          state_nx = S_SL_WR;
        end
      end
      S_SL_WR: begin
        if (ss_ok) begin
          if (addr + 32'd1 < cnt) begin
            addr_nx  = addr + 32'd1;
            state_nx = S_MEM_RD;
          end else begin
            state_nx = S_HDR_RD;
          end
        end else if (tmo) begin
          err_nx   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
      idx   <= 9'd0;
      cnt   <= 32'd0;
      addr  <= 32'd0;
      maddr <= 32'd0;
      dat   <= 64'd0;
      gap   <= 1'b0;
      tcnt  <= 16'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      addr  <= addr_nx;
      maddr <= maddr_nx;
      dat   <= dat_nx;
      gap   <= gap_nx;
      tcnt  <= tcnt_nx;
      err   <= err_nx;
    end
  end

endmodule

// File: tb/tb_ss_bus_master.sv
// Bench for ss_bus_master: behavioural slaves and memory, scoreboard queues
// of expected memory writes and slave writes, popped by a monitor process.
module tb_ss_bus_master;

  localparam int NS  = 16;
  localparam int TMO = 20;

  logic        clock, reset_n, cmd_save, cmd_restore;
  logic        busy, done, error;
  logic [7:0]  ss_select;
  logic [31:0] ss_addr, mem_addr;
  logic        ss_query, ss_read, ss_write, mem_rd, mem_wr;
  logic [63:0] ss_wdata, ss_rdata, mem_wdata, mem_rdata;
  logic        ss_ack, mem_ack;

  ss_bus_master #(.NUM_SLAVES(NS), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_save(cmd_save), .cmd_restore(cmd_restore),
    .busy(busy), .done(done), .error(error),
    .ss_select(ss_select), .ss_addr(ss_addr), .ss_query(ss_query), .ss_read(ss_read),
    .ss_write(ss_write), .ss_wdata(ss_wdata), .ss_ack(ss_ack), .ss_rdata(ss_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  typedef struct { logic [31:0] a; logic [63:0] d; } mexp_t;
  typedef struct { logic [7:0] i; logic [31:0] a; logic [63:0] d; } sexp_t;

  mexp_t mq[$];
  sexp_t sq[$];
  int    n_chk = 0, n_fail = 0;
  int    done_cnt = 0, cyc = 0;
  bit    chk_en = 1, mem_rd_seen = 0;

  bit          sl_q[NS];
  bit          sl_rd[NS];
  logic [31:0] sl_cnt[NS];
  logic [63:0] sl_mem[NS][8];
  logic [63:0] mem[64];

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] sdata(input int i, input int a);
    return {16'hC0DE, 8'(i), 8'(a), 32'h5EED_0000 + 32'(a * 3 + i)};
  endfunction

  // Slave responder: acks one cycle after the strobe is seen
  initial begin
    bit w;
    int s;
    w = 0; ss_ack = 0; ss_rdata = '0;
    forever begin
      @(negedge clock);
      s = int'(ss_select[3:0]);
      if (ss_ack) ss_ack = 0;
      else if (ss_query || ss_read || ss_write) begin
        if (!w) w = 1;
        else begin
          w = 0;
          if (ss_query && sl_q[s]) begin
            ss_ack = 1; ss_rdata = {32'd0, sl_cnt[s]};
          end else if (ss_read && sl_rd[s]) begin
            ss_ack = 1; ss_rdata = sl_mem[s][ss_addr[2:0]];
          end else if (ss_write) begin
            ss_ack = 1; sl_mem[s][ss_addr[2:0]] = ss_wdata;
          end
        end
      end else w = 0;
    end
  end

  // Memory responder: always acks one cycle after the request
  initial begin
    bit w;
    w = 0; mem_ack = 0; mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_ack) mem_ack = 0;
      else if (mem_rd || mem_wr) begin
        if (!w) w = 1;
        else begin
          w = 0; mem_ack = 1;
          if (mem_rd) mem_rdata = mem[mem_addr[5:0]];
          else mem[mem_addr[5:0]] = mem_wdata;
        end
      end else w = 0;
    end
  end

  // Monitor: pops expectations on every completed write handshake
  initial forever begin
    mexp_t me;
    sexp_t se;
    @(negedge clock); #1;
    if (mem_rd) mem_rd_seen = 1;
    if (chk_en && mem_wr && mem_ack) begin
      if (mq.size() == 0) chk("mem_wr_unexpected", {32'd0, mem_addr}, 64'hX);
      else begin
        me = mq.pop_front();
        chk("mem_wr_addr", {32'd0, mem_addr}, {32'd0, me.a});
        chk("mem_wr_data", mem_wdata, me.d);
      end
    end
    if (chk_en && ss_write && ss_ack) begin
      if (sq.size() == 0) chk("ss_wr_unexpected", {24'd0, ss_select, ss_addr}, 64'hX);
      else begin
        se = sq.pop_front();
        chk("ss_wr_sel_addr", {24'd0, ss_select, ss_addr}, {24'd0, se.i, se.a});
        chk("ss_wr_data", ss_wdata, se.d);
      end
    end
    if (done) begin
      done_cnt++;
      chk("busy_low_at_done", {63'd0, busy}, 64'd0);
    end
  end

  task automatic push_m(input logic [31:0] a, input logic [63:0] d);
    mexp_t e;
    e.a = a; e.d = d;
    mq.push_back(e);
  endtask

  task automatic push_s(input logic [7:0] i, input logic [31:0] a, input logic [63:0] d);
    sexp_t e;
    e.i = i; e.a = a; e.d = d;
    sq.push_back(e);
  endtask

  task automatic cfg_clear();
    for (int i = 0; i < NS; i++) begin
      sl_q[i] = 0; sl_rd[i] = 1; sl_cnt[i] = 32'd0;
      for (int a = 0; a < 8; a++) sl_mem[i][a] = sdata(i, a);
    end
  endtask

  task automatic pulse(input bit s, input bit r);
    @(negedge clock);
    cmd_save = s; cmd_restore = r;
    @(negedge clock);
    cmd_save = 0; cmd_restore = 0;
  endtask

  task automatic wait_done(input string nm);
    int  d0;
    bit  ok;
    d0 = done_cnt; ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock); #2;
      if (done_cnt != d0) begin ok = 1; break; end
      if (error) break;
    end
    chk(nm, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    int t0, t1, d0;
    bit ok;
    reset_n = 0; cmd_save = 0; cmd_restore = 0;
    cfg_clear();
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_flags", {61'd0, busy, done, error}, 64'd0);
    chk("rst_strobes", {59'd0, ss_query, ss_read, ss_write, mem_rd, mem_wr}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    reset_n = 1;

    // Save: slaves 0 (4 words) and 3 (2 words); slave 5 reports size 0
    sl_q[0] = 1; sl_cnt[0] = 32'd4;
    sl_q[3] = 1; sl_cnt[3] = 32'd2;
    sl_q[5] = 1; sl_cnt[5] = 32'd0;
    push_m(32'd0, 64'h0000_0000_0000_0004);
    for (int a = 0; a < 4; a++) push_m(32'(a + 1), sdata(0, a));
    push_m(32'd5, 64'h0000_0003_0000_0002);
    for (int a = 0; a < 2; a++) push_m(32'(a + 6), sdata(3, a));
    push_m(32'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    pulse(1, 1);
    chk("save_busy", {63'd0, busy}, 64'd1);
    repeat (4) @(negedge clock);
    pulse(0, 1);
    wait_done("save_done");
    chk("save_error", {63'd0, error}, 64'd0);
    chk("save_queue_empty", 64'(mq.size()), 64'd0);
    chk("save_no_mem_rd", {63'd0, mem_rd_seen}, 64'd0);

    // Restore the image just written
    for (int a = 0; a < 4; a++) push_s(8'd0, 32'(a), sdata(0, a));
    for (int a = 0; a < 2; a++) push_s(8'd3, 32'(a), sdata(3, a));
    for (int i = 0; i < NS; i++) for (int a = 0; a < 8; a++) sl_mem[i][a] = '0;
    pulse(0, 1);
    wait_done("restore_done");
    chk("restore_error", {63'd0, error}, 64'd0);
    chk("restore_queue_empty", 64'(sq.size()), 64'd0);

    // Slave 1 answers the query but never a read
    cfg_clear();
    sl_q[1] = 1; sl_cnt[1] = 32'd3; sl_rd[1] = 0;
    push_m(32'd0, 64'h0000_0001_0000_0003);
    d0 = done_cnt;
    pulse(1, 0);
    ok = 0; t0 = 0; t1 = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock); #2;
      if (ss_read) begin ok = 1; t0 = cyc; break; end
    end
    chk("tmo_read_seen", {63'd0, ok}, 64'd1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock); #2;
      if (error) begin ok = 1; t1 = cyc; break; end
    end
    chk("tmo_error_set", {63'd0, ok}, 64'd1);
    chk("tmo_window", {63'd0, (t1 - t0 >= TMO) && (t1 - t0 <= TMO + 2)}, 64'd1);
    chk("tmo_busy", {63'd0, busy}, 64'd0);
    chk("tmo_read_dropped", {63'd0, ss_read}, 64'd0);
    chk("tmo_no_done", 64'(done_cnt - d0), 64'd0);
    chk("tmo_queue_empty", 64'(mq.size()), 64'd0);

    // Reset while a data word is being written to memory
    cfg_clear();
    sl_q[0] = 1; sl_cnt[0] = 32'd4;
    chk_en = 0;
    pulse(1, 0);
    chk("error_cleared_on_cmd", {63'd0, error}, 64'd0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock); #2;
      if (mem_wr && mem_addr == 32'd2) begin ok = 1; break; end
    end
    chk("rstmid_reached_mem_wr", {63'd0, ok}, 64'd1);
    reset_n = 0;
    @(negedge clock); #1;
    chk("rstmid_strobes", {59'd0, ss_query, ss_read, ss_write, mem_rd, mem_wr}, 64'd0);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    reset_n = 1;
    mq.delete();
    push_m(32'd0, 64'h0000_0000_0000_0004);
    for (int a = 0; a < 4; a++) push_m(32'(a + 1), sdata(0, a));
    push_m(32'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clock); #3;
    chk_en = 1;
    pulse(1, 0);
    wait_done("restart_done");
    chk("restart_error", {63'd0, error}, 64'd0);
    chk("restart_queue_empty", 64'(mq.size()), 64'd0);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
